// File: rtl/logic_queue_synchronous.sv
// rtl/logic_queue_synchronous.sv - single-clock AXI4-Stream queue with registered ready/valid and occupancy level
module logic_queue_synchronous #(
  parameter int WIDTH    = 1,
  parameter int CAPACITY = 256
) (
  input  logic                            aclk,
  input  logic                            areset_n,
  input  logic                            rx_tvalid,
  input  logic [WIDTH-1:0]                rx_tdata,
  output logic                            rx_tready,
  output logic                            tx_tvalid,
  output logic [WIDTH-1:0]                tx_tdata,
  input  logic                            tx_tready,
  output logic [$clog2(CAPACITY+1)-1:0]   level
);

  localparam int PW = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam int LW = $clog2(CAPACITY + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(CAPACITY - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] FULL_CNT = LW'(CAPACITY);
  localparam logic [LW-1:0] CNT_ONE  = LW'(1);

  logic [WIDTH-1:0] mem_q [CAPACITY];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             rx_tready_q;
  logic             tx_tvalid_q;
  logic             push;
  logic             pop;

  // Handshakes use only registered ready/valid, so neither side sees a combinational path.
  assign push = rx_tvalid && rx_tready_q;
  assign pop  = tx_tvalid_q && tx_tready;

  // Next pointers (explicit wrap, so non-power-of-two depths work) and next occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state; flags are derived from next occupancy so they are valid right after each edge.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_tready_q <= 1'b0;
      tx_tvalid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_tready_q <= (count_d != FULL_CNT);
      tx_tvalid_q <= (count_d != '0);
    end
  end

  // Beat storage; contents need no reset because valid tracks occupancy.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_tdata;
    end
  end

  assign tx_tdata  = mem_q[rd_ptr_q];
  assign rx_tready = rx_tready_q;
  assign tx_tvalid = tx_tvalid_q;
  assign level     = count_q;

endmodule

// File: tb/tb_logic_queue_synchronous.sv
// tb/tb_logic_queue_synchronous.sv - randomized self-checking bench for logic_queue_synchronous
module tb_logic_queue_synchronous;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_rx_tvalid, a_rx_tready, a_tx_tvalid, a_tx_tready;
  logic [7:0] a_rx_tdata, a_tx_tdata;
  logic [2:0] a_level;
  logic       b_rx_tvalid, b_rx_tready, b_tx_tvalid, b_tx_tready;
  logic [7:0] b_rx_tdata, b_tx_tdata;
  logic [1:0] b_level;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain FIFOs of accepted beats plus a flag for "one edge seen out of reset".
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         live = 1'b0;

  logic_queue_synchronous #(.WIDTH(8), .CAPACITY(4)) u_a (
    .aclk(clk), .areset_n(rst_n),
    .rx_tvalid(a_rx_tvalid), .rx_tdata(a_rx_tdata), .rx_tready(a_rx_tready),
    .tx_tvalid(a_tx_tvalid), .tx_tdata(a_tx_tdata), .tx_tready(a_tx_tready),
    .level(a_level)
  );

  logic_queue_synchronous #(.WIDTH(8), .CAPACITY(3)) u_b (
    .aclk(clk), .areset_n(rst_n),
    .rx_tvalid(b_rx_tvalid), .rx_tdata(b_rx_tdata), .rx_tready(b_rx_tready),
    .tx_tvalid(b_tx_tvalid), .tx_tdata(b_tx_tdata), .tx_tready(b_tx_tready),
    .level(b_level)
  );

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic tick();
    logic r, pa, ppa, pb, ppb;
    logic [7:0] da, db;
    r   = rst_n;
    pa  = r && live && a_rx_tvalid && (qa.size() < 4);
    ppa = r && a_tx_tready && (qa.size() > 0);
    pb  = r && live && b_rx_tvalid && (qb.size() < 3);
    ppb = r && b_tx_tready && (qb.size() > 0);
    da  = a_rx_tdata;
    db  = b_rx_tdata;
    @(posedge clk);
    #1;
    if (!r) begin
      qa.delete();
      qb.delete();
      live = 1'b0;
    end else begin
      if (ppa) void'(qa.pop_front());
      if (pa) qa.push_back(da);
      if (ppb) void'(qb.pop_front());
      if (pb) qb.push_back(db);
      live = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_rx_tvalid = 1'b0; a_rx_tdata = 8'h00; a_tx_tready = 1'b0;
    b_rx_tvalid = 1'b0; b_rx_tdata = 8'h00; b_tx_tready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (a_rx_tready !== 1'b0) $display("FAIL reset_rx_tready: got %b want 0", a_rx_tready); else n_pass++;
      n_total++; if (a_tx_tvalid !== 1'b0) $display("FAIL reset_tx_tvalid: got %b want 0", a_tx_tvalid); else n_pass++;
      n_total++; if (a_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", a_level); else n_pass++;
      n_total++; if (b_rx_tready !== 1'b0) $display("FAIL reset_b_rx_tready: got %b want 0", b_rx_tready); else n_pass++;
      tick();
    end
    // Offer a beat across the release edge: ready is still low, so it must not be taken.
    a_rx_tvalid = 1'b1; a_rx_tdata = 8'h33;
    rst_n = 1'b1;
    tick();
    a_rx_tvalid = 1'b0;
    n_total++; if (a_rx_tready !== 1'b1) $display("FAIL release_rx_tready: got %b want 1", a_rx_tready); else n_pass++;
    n_total++; if (a_tx_tvalid !== 1'b0) $display("FAIL release_tx_tvalid: got %b want 0", a_tx_tvalid); else n_pass++;
    n_total++; if (a_level !== 3'd0) $display("FAIL release_level: got %0d want 0", a_level); else n_pass++;
    n_total++; if (b_rx_tready !== 1'b1) $display("FAIL release_b_rx_tready: got %b want 1", b_rx_tready); else n_pass++;
  endtask

  task automatic test_single();
    a_tx_tready = 1'b0;
    a_rx_tvalid = 1'b1; a_rx_tdata = 8'hA5;
    tick();
    a_rx_tvalid = 1'b0;
    n_total++; if (a_tx_tvalid !== 1'b1) $display("FAIL single_tx_tvalid: got %b want 1", a_tx_tvalid); else n_pass++;
    n_total++; if (a_tx_tdata !== 8'hA5) $display("FAIL single_tx_tdata: got %h want a5", a_tx_tdata); else n_pass++;
    n_total++; if (a_level !== 3'd1) $display("FAIL single_level: got %0d want 1", a_level); else n_pass++;
    a_tx_tready = 1'b1;
    tick();
    a_tx_tready = 1'b0;
    n_total++; if (a_tx_tvalid !== 1'b0) $display("FAIL single_pop_tx_tvalid: got %b want 0", a_tx_tvalid); else n_pass++;
    n_total++; if (a_level !== 3'd0) $display("FAIL single_pop_level: got %0d want 0", a_level); else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [7:0] nxt;
    logic [7:0] got[$];
    logic [7:0] exp;
    bit acc;
    nxt = 8'h01;
    a_tx_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_rx_tvalid = 1'b1; a_rx_tdata = nxt;
      acc = live && (qa.size() < 4);
      tick();
      if (acc) nxt = nxt + 8'h01;
    end
    n_total++; if (a_level !== 3'd4) $display("FAIL full_level: got %0d want 4", a_level); else n_pass++;
    n_total++; if (a_rx_tready !== 1'b0) $display("FAIL full_rx_tready: got %b want 0", a_rx_tready); else n_pass++;
    n_total++; if (a_rx_tdata !== 8'h05) $display("FAIL full_held_beat: got %h want 05", a_rx_tdata); else n_pass++;
    a_tx_tready = 1'b1;
    for (int i = 0; i < 20 && got.size() < 5; i++) begin
      if (i == 1) begin
        n_total++; if (a_rx_tready !== 1'b1) $display("FAIL full_pop_rx_tready: got %b want 1", a_rx_tready); else n_pass++;
      end
      if (a_tx_tvalid) got.push_back(a_tx_tdata);
      acc = a_rx_tvalid && live && (qa.size() < 4);
      tick();
      if (acc) a_rx_tvalid = 1'b0;
    end
    a_tx_tready = 1'b0;
    a_rx_tvalid = 1'b0;
    n_total++; if (got.size() != 5) $display("FAIL drain_count: got %0d want 5", got.size()); else n_pass++;
    for (int i = 0; i < got.size(); i++) begin
      exp = 8'(i + 1);
      n_total++; if (got[i] !== exp) $display("FAIL drain_order[%0d]: got %h want %h", i, got[i], exp); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    a_tx_tready = 1'b0;
    a_rx_tvalid = 1'b1; a_rx_tdata = 8'h10; tick();
    a_rx_tdata = 8'h11; tick();
    a_tx_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_rx_tdata = 8'(8'h12 + i);
      exp = 8'(8'h10 + i);
      n_total++; if (a_rx_tready !== 1'b1) $display("FAIL b2b_rx_tready[%0d]: got %b want 1", i, a_rx_tready); else n_pass++;
      n_total++; if (a_tx_tvalid !== 1'b1) $display("FAIL b2b_tx_tvalid[%0d]: got %b want 1", i, a_tx_tvalid); else n_pass++;
      n_total++; if (a_level !== 3'd2) $display("FAIL b2b_level[%0d]: got %0d want 2", i, a_level); else n_pass++;
      n_total++; if (a_tx_tdata !== exp) $display("FAIL b2b_tx_tdata[%0d]: got %h want %h", i, a_tx_tdata, exp); else n_pass++;
      tick();
    end
    a_rx_tvalid = 1'b0;
    for (int i = 0; i < 10 && qa.size() > 0; i++) tick();
    a_tx_tready = 1'b0;
    n_total++; if (a_level !== 3'd0) $display("FAIL b2b_drained_level: got %0d want 0", a_level); else n_pass++;
  endtask

  task automatic test_wrap();
    int nxt;
    logic [7:0] got[$];
    logic [7:0] held;
    logic [7:0] exp;
    bit stall, acc;
    nxt = 0; stall = 1'b0; held = 8'h00;
    for (int cyc = 0; cyc < 3000 && got.size() < 100; cyc++) begin
      n_total++; if (b_rx_tready !== (live && qb.size() != 3)) $display("FAIL wrap_rx_tready@%0d: got %b want %b", cyc, b_rx_tready, (live && qb.size() != 3)); else n_pass++;
      n_total++; if (b_tx_tvalid !== (qb.size() != 0)) $display("FAIL wrap_tx_tvalid@%0d: got %b want %b", cyc, b_tx_tvalid, (qb.size() != 0)); else n_pass++;
      n_total++; if (int'(b_level) != qb.size()) $display("FAIL wrap_level@%0d: got %0d want %0d", cyc, b_level, qb.size()); else n_pass++;
      if (qb.size() > 0) begin
        n_total++; if (b_tx_tdata !== qb[0]) $display("FAIL wrap_tx_tdata@%0d: got %h want %h", cyc, b_tx_tdata, qb[0]); else n_pass++;
      end
      if (stall) begin
        n_total++; if (b_tx_tvalid !== 1'b1 || b_tx_tdata !== held) $display("FAIL wrap_stable@%0d: got %b/%h want 1/%h", cyc, b_tx_tvalid, b_tx_tdata, held); else n_pass++;
      end
      b_rx_tvalid = (nxt < 100) && ($urandom_range(0, 3) != 0);
      b_rx_tdata  = 8'(nxt);
      b_tx_tready = ($urandom_range(0, 2) != 0);
      acc = b_rx_tvalid && live && (qb.size() < 3);
      if (b_tx_tvalid && b_tx_tready) got.push_back(b_tx_tdata);
      stall = b_tx_tvalid && !b_tx_tready;
      held  = b_tx_tdata;
      tick();
      if (acc) nxt++;
    end
    b_rx_tvalid = 1'b0;
    b_tx_tready = 1'b0;
    n_total++; if (got.size() != 100) $display("FAIL wrap_count: got %0d want 100", got.size()); else n_pass++;
    for (int i = 0; i < got.size(); i++) begin
      exp = 8'(i);
      n_total++; if (got[i] !== exp) $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], exp); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    a_tx_tready = 1'b0;
    a_rx_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_rx_tdata = 8'(8'h61 + i);
      tick();
    end
    a_rx_tvalid = 1'b0;
    n_total++; if (a_level !== 3'd3) $display("FAIL midrst_pre_level: got %0d want 3", a_level); else n_pass++;
    rst_n = 1'b0;
    #2;
    n_total++; if (a_tx_tvalid !== 1'b0) $display("FAIL midrst_tx_tvalid: got %b want 0", a_tx_tvalid); else n_pass++;
    n_total++; if (a_rx_tready !== 1'b0) $display("FAIL midrst_rx_tready: got %b want 0", a_rx_tready); else n_pass++;
    n_total++; if (a_level !== 3'd0) $display("FAIL midrst_level: got %0d want 0", a_level); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (a_rx_tready !== 1'b1) $display("FAIL midrst_release_rx_tready: got %b want 1", a_rx_tready); else n_pass++;
    a_rx_tvalid = 1'b1; a_rx_tdata = 8'h7E;
    tick();
    a_rx_tvalid = 1'b0;
    n_total++; if (a_tx_tvalid !== 1'b1) $display("FAIL midrst_new_tx_tvalid: got %b want 1", a_tx_tvalid); else n_pass++;
    n_total++; if (a_tx_tdata !== 8'h7E) $display("FAIL midrst_new_tx_tdata: got %h want 7e", a_tx_tdata); else n_pass++;
    n_total++; if (a_level !== 3'd1) $display("FAIL midrst_new_level: got %0d want 1", a_level); else n_pass++;
    a_tx_tready = 1'b1;
    tick();
    a_tx_tready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

endmodule
